// File: rtl/i_cache_nway_if.sv
// Bus interfaces for the instruction cache: SRAM-like CPU port and AXI-like read channel.

interface i_cache_nway_cpu_if;
   logic        cpu_inst_req;
   logic        cpu_inst_wr;
   logic [1:0]  cpu_inst_size;
   logic [31:0] cpu_inst_addr;
   logic [31:0] cpu_inst_wdata;
   logic [31:0] cpu_inst_rdata;
   logic        cpu_inst_addr_ok;
   logic        cpu_inst_data_ok;

   modport master (
      output cpu_inst_req, cpu_inst_wr, cpu_inst_size, cpu_inst_addr, cpu_inst_wdata,
      input  cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok
   );

   modport slave (
      input  cpu_inst_req, cpu_inst_wr, cpu_inst_size, cpu_inst_addr, cpu_inst_wdata,
      output cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok
   );
endinterface

interface i_cache_nway_axi_if;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output araddr, arlen, arsize, arvalid, rready,
      input  arready, rdata, rlast, rvalid
   );

   modport slave (
      input  araddr, arlen, arsize, arvalid, rready,
      output arready, rdata, rlast, rvalid
   );
endinterface

// File: rtl/i_cache_nway.sv
// N-way set-associative read-only instruction cache with FIFO replacement,
// early-restart refill, an uncached address window and flush.

module i_cache_nway #(
   parameter int unsigned INDEX_WIDTH  = 7,
   parameter int unsigned OFFSET_WIDTH = 5,
   parameter int unsigned WAY_NUM      = 2,
   parameter logic [31:0] UNC_MASK     = 32'hE000_0000,
   parameter logic [31:0] UNC_MATCH    = 32'hA000_0000
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 flush,
   i_cache_nway_cpu_if.slave   cpu,
   i_cache_nway_axi_if.master  axi
);
   localparam int unsigned TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int unsigned WORD_WIDTH = OFFSET_WIDTH - 2;
   localparam int unsigned WORDS      = 1 << WORD_WIDTH;
   localparam int unsigned SETS       = 1 << INDEX_WIDTH;
   localparam int unsigned PTR_WIDTH  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

   typedef enum logic [1:0] {IDLE, AR, R} state_t;

   state_t                  state;
   logic [WAY_NUM-1:0]      valid_q [SETS];
   logic [PTR_WIDTH-1:0]    ptr_q   [SETS];
   logic [TAG_WIDTH-1:0]    tag_q   [SETS][WAY_NUM];
   logic [31:0]             data_q  [SETS][WAY_NUM][WORDS];

   logic [TAG_WIDTH-1:0]    miss_tag;
   logic [INDEX_WIDTH-1:0]  miss_index;
   logic [WORD_WIDTH-1:0]   miss_word;
   logic [WORD_WIDTH-1:0]   beat_cnt;
   logic [PTR_WIDTH-1:0]    miss_way;
   logic                    miss_from_ptr;
   logic                    miss_unc;
   logic                    flush_pend;
   logic                    arvalid_q;
   logic                    rready_q;
   logic [31:0]             araddr_q;
   logic [7:0]              arlen_q;

   logic [TAG_WIDTH-1:0]    req_tag;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic [WORD_WIDTH-1:0]   req_word;
   logic                    req_unc;
   logic                    flush_any;
   logic                    hit;
   logic [PTR_WIDTH-1:0]    hit_way;
   logic [31:0]             hit_data;
   logic [PTR_WIDTH-1:0]    victim_way;
   logic                    victim_ptr;
   logic                    addr_ok;
   logic                    data_ok;
   logic [31:0]             rdata_out;
   logic                    unused_bits;

   assign req_tag     = cpu.cpu_inst_addr[31 -: TAG_WIDTH];
   assign req_index   = cpu.cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_word    = cpu.cpu_inst_addr[2 +: WORD_WIDTH];
   assign req_unc     = (cpu.cpu_inst_addr & UNC_MASK) == UNC_MATCH;
   assign flush_any   = flush | flush_pend;
   assign unused_bits = ^{cpu.cpu_inst_size, cpu.cpu_inst_wdata, cpu.cpu_inst_addr[1:0]};

   // Tag compare and victim selection (lowest invalid way, else FIFO pointer).
   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      victim_way = ptr_q[req_index];
      victim_ptr = 1'b1;
      for (int w = int'(WAY_NUM) - 1; w >= 0; w--) begin
         if (!valid_q[req_index][PTR_WIDTH'(w)]) begin
            victim_way = PTR_WIDTH'(w);
            victim_ptr = 1'b0;
         end
      end
      for (int w = 0; w < int'(WAY_NUM); w++) begin
         if (valid_q[req_index][PTR_WIDTH'(w)] && tag_q[req_index][PTR_WIDTH'(w)] == req_tag) begin
            hit     = 1'b1;
            hit_way = PTR_WIDTH'(w);
         end
      end
      hit_data = data_q[req_index][hit_way][req_word];
   end

   // CPU-side acknowledges: same-cycle hits and early-restart beat forwarding.
   always_comb begin
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
      rdata_out = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (cpu.cpu_inst_req && !flush_any) begin
                  if (cpu.cpu_inst_wr) begin
                     addr_ok = 1'b1;
                     data_ok = 1'b1;
                  end else if (!req_unc && hit) begin
                     addr_ok   = 1'b1;
                     data_ok   = 1'b1;
                     rdata_out = hit_data;
                  end
               end
            end
            AR: addr_ok = arvalid_q & axi.arready;
            R: begin
               if (axi.rvalid && (miss_unc || beat_cnt == miss_word)) begin
                  data_ok   = 1'b1;
                  rdata_out = axi.rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu.cpu_inst_addr_ok = addr_ok;
   assign cpu.cpu_inst_data_ok = data_ok;
   assign cpu.cpu_inst_rdata   = rdata_out;
   assign axi.araddr           = araddr_q;
   assign axi.arlen            = arlen_q;
   assign axi.arsize           = 3'd2;
   assign axi.arvalid          = arvalid_q;
   assign axi.rready           = rready_q;

   // Miss FSM, valid bits, FIFO pointers and pending flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         flush_pend    <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         araddr_q      <= '0;
         arlen_q       <= '0;
         beat_cnt      <= '0;
         miss_tag      <= '0;
         miss_index    <= '0;
         miss_word     <= '0;
         miss_way      <= '0;
         miss_from_ptr <= 1'b0;
         miss_unc      <= 1'b0;
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[INDEX_WIDTH'(s)] <= '0;
            ptr_q[INDEX_WIDTH'(s)]   <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (flush_any) begin
                  flush_pend <= 1'b0;
                  for (int s = 0; s < int'(SETS); s++) begin
                     valid_q[INDEX_WIDTH'(s)] <= '0;
                     ptr_q[INDEX_WIDTH'(s)]   <= '0;
                  end
               end else if (cpu.cpu_inst_req && !cpu.cpu_inst_wr && (req_unc || !hit)) begin
                  miss_tag      <= req_tag;
                  miss_index    <= req_index;
                  miss_word     <= req_word;
                  miss_way      <= victim_way;
                  miss_from_ptr <= victim_ptr;
                  miss_unc      <= req_unc;
                  arvalid_q     <= 1'b1;
                  araddr_q      <= req_unc ? {cpu.cpu_inst_addr[31:2], 2'b00}
                                           : {cpu.cpu_inst_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                  arlen_q       <= req_unc ? 8'd0 : 8'(WORDS - 1);
                  state         <= AR;
               end
            end
            AR: begin
               if (flush) flush_pend <= 1'b1;
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  beat_cnt  <= '0;
                  state     <= R;
               end
            end
            R: begin
               if (flush) flush_pend <= 1'b1;
               if (axi.rvalid) begin
                  beat_cnt <= beat_cnt + WORD_WIDTH'(1);
                  if (axi.rlast || miss_unc) begin
                     rready_q <= 1'b0;
                     beat_cnt <= '0;
                     state    <= IDLE;
                     if (!miss_unc) begin
                        valid_q[miss_index][miss_way] <= 1'b1;
                        if (miss_from_ptr)
                           ptr_q[miss_index] <= (WAY_NUM == 1) ? '0 : ptr_q[miss_index] + PTR_WIDTH'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Refill write port for line data and tag; arrays are not reset.
   always_ff @(posedge clk) begin
      if (state == R && axi.rvalid && !miss_unc) begin
         data_q[miss_index][miss_way][beat_cnt] <= axi.rdata;
         if (axi.rlast) tag_q[miss_index][miss_way] <= miss_tag;
      end
   end

endmodule

// File: tb/tb_i_cache_nway.sv
// Directed self-checking bench for i_cache_nway (default parameters: 2 ways, 8 words/line).

module tb_i_cache_nway;
   logic clk;
   logic rst;
   logic flush;
   int   n_cmp;
   int   n_err;

   i_cache_nway_cpu_if cpu_if ();
   i_cache_nway_axi_if axi_if ();

   i_cache_nway dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .cpu   (cpu_if.slave),
      .axi   (axi_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a read expected to miss; serve the burst with beat data seed+i.
   task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_araddr,
                          input int len, input int word, input logic [31:0] seed,
                          input int stall_at, input int flush_at, input int rst_at);
      cpu_if.cpu_inst_req  = 1'b1;
      cpu_if.cpu_inst_wr   = 1'b0;
      cpu_if.cpu_inst_addr = addr;
      #1;
      check("miss_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd0);
      check("miss_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd0);
      tick();
      check("arvalid", 32'(axi_if.arvalid), 32'd1);
      check("araddr", axi_if.araddr, exp_araddr);
      check("arlen", 32'(axi_if.arlen), 32'(len));
      check("arsize", 32'(axi_if.arsize), 32'd2);
      axi_if.arready = 1'b1;
      #1;
      check("ar_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd1);
      tick();
      axi_if.arready      = 1'b0;
      cpu_if.cpu_inst_req = 1'b0;
      check("rready", 32'(axi_if.rready), 32'd1);
      for (int i = 0; i <= len; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < 3; s++) begin
               axi_if.rvalid = 1'b0;
               #1;
               check("stall_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd0);
               tick();
            end
         end
         if (i == rst_at) begin
            rst           = 1'b1;
            axi_if.rvalid = 1'b0;
            tick();
            rst = 1'b0;
            check("rst_arvalid", 32'(axi_if.arvalid), 32'd0);
            check("rst_rready", 32'(axi_if.rready), 32'd0);
            return;
         end
         axi_if.rvalid = 1'b1;
         axi_if.rdata  = seed + 32'(i);
         axi_if.rlast  = (i == len);
         flush         = (i == flush_at);
         #1;
         check("beat_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'(i == word));
         if (i == word) check("beat_rdata", cpu_if.cpu_inst_rdata, seed + 32'(i));
         tick();
         flush = 1'b0;
      end
      axi_if.rvalid = 1'b0;
      axi_if.rlast  = 1'b0;
   endtask

   // Drive a read expected to hit in the same cycle.
   task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp_data);
      cpu_if.cpu_inst_req  = 1'b1;
      cpu_if.cpu_inst_wr   = 1'b0;
      cpu_if.cpu_inst_addr = addr;
      #1;
      check("hit_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd1);
      check("hit_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd1);
      check("hit_rdata", cpu_if.cpu_inst_rdata, exp_data);
      tick();
      cpu_if.cpu_inst_req = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      flush = 1'b0;
      cpu_if.cpu_inst_req   = 1'b0;
      cpu_if.cpu_inst_wr    = 1'b0;
      cpu_if.cpu_inst_size  = 2'd2;
      cpu_if.cpu_inst_addr  = '0;
      cpu_if.cpu_inst_wdata = '0;
      axi_if.arready = 1'b0;
      axi_if.rdata   = '0;
      axi_if.rlast   = 1'b0;
      axi_if.rvalid  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd0);
      check("rst_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd0);
      check("rst_rdata", cpu_if.cpu_inst_rdata, 32'd0);
      check("rst_arvalid0", 32'(axi_if.arvalid), 32'd0);
      check("rst_rready0", 32'(axi_if.rready), 32'd0);
      tick();

      // Cold miss with early restart, then hit on the refilled line.
      do_miss(32'h0000_1014, 32'h0000_1000, 7, 5, 32'h100, -1, -1, -1);
      do_hit(32'h0000_1018, 32'h106);
      do_hit(32'h0000_1000, 32'h100);

      // Flush in IDLE: no acks in the flush cycle, then the line misses.
      flush                = 1'b1;
      cpu_if.cpu_inst_req  = 1'b1;
      cpu_if.cpu_inst_addr = 32'h0000_1000;
      #1;
      check("flush_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd0);
      check("flush_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd0);
      tick();
      flush = 1'b0;
      do_miss(32'h0000_1000, 32'h0000_1000, 7, 0, 32'h100, -1, -1, -1);

      // FIFO replacement on set 0 from a clean cache.
      cpu_if.cpu_inst_req = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      do_miss(32'h0000_0000, 32'h0000_0000, 7, 0, 32'h200, -1, -1, -1);
      do_miss(32'h0000_1000, 32'h0000_1000, 7, 0, 32'h100, -1, -1, -1);
      do_miss(32'h0000_2000, 32'h0000_2000, 7, 0, 32'h300, -1, -1, -1);
      do_hit(32'h0000_1000, 32'h100);
      do_miss(32'h0000_0000, 32'h0000_0000, 7, 0, 32'h400, -1, -1, -1);
      do_hit(32'h0000_2004, 32'h301);
      do_hit(32'h0000_0008, 32'h402);
      do_miss(32'h0000_1000, 32'h0000_1000, 7, 0, 32'h100, -1, -1, -1);

      // Uncached window: single-beat read, never allocated.
      do_miss(32'hA000_0010, 32'hA000_0010, 0, 0, 32'hDEAD_0000, -1, -1, -1);
      do_miss(32'hA000_0010, 32'hA000_0010, 0, 0, 32'hBEEF_0000, -1, -1, -1);

      // Flush during refill: data still returned, line invalid afterwards.
      do_miss(32'h0000_3004, 32'h0000_3000, 7, 1, 32'h600, -1, 3, -1);
      cpu_if.cpu_inst_req  = 1'b1;
      cpu_if.cpu_inst_addr = 32'h0000_3004;
      #1;
      check("pend_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd0);
      check("pend_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd0);
      tick();
      do_miss(32'h0000_3004, 32'h0000_3000, 7, 1, 32'h700, -1, -1, -1);

      // Stalled burst still returns the requested word.
      do_miss(32'h0000_500C, 32'h0000_5000, 7, 3, 32'h500, 3, -1, -1);
      do_hit(32'h0000_5008, 32'h502);

      // Write request: immediate ack, zero data, no AR.
      cpu_if.cpu_inst_req  = 1'b1;
      cpu_if.cpu_inst_wr   = 1'b1;
      cpu_if.cpu_inst_addr = 32'h0000_1000;
      #1;
      check("wr_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd1);
      check("wr_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd1);
      check("wr_rdata", cpu_if.cpu_inst_rdata, 32'd0);
      tick();
      cpu_if.cpu_inst_req = 1'b0;
      cpu_if.cpu_inst_wr  = 1'b0;
      check("wr_no_ar", 32'(axi_if.arvalid), 32'd0);

      // Reset mid-burst aborts, and previously filled lines are gone.
      do_miss(32'h0000_6000, 32'h0000_6000, 7, 0, 32'h800, -1, -1, 4);
      cpu_if.cpu_inst_req  = 1'b1;
      cpu_if.cpu_inst_addr = 32'h0000_500C;
      #1;
      check("post_rst_addr_ok", 32'(cpu_if.cpu_inst_addr_ok), 32'd0);
      check("post_rst_data_ok", 32'(cpu_if.cpu_inst_data_ok), 32'd0);
      tick();
      check("post_rst_arvalid", 32'(axi_if.arvalid), 32'd1);
      cpu_if.cpu_inst_req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
